// File: rtl/seq_accum.sv
// seq_accum: sums COUNT unsigned 4-bit samples into a SUM_W-bit total and
// presents the total with a sticky overflow flag on a valid/ready output.
// Optional feature: define SEQ_ACCUM_SAT_EN for saturating accumulation;
// with the macro undefined the accumulator wraps around.
module seq_accum #(
  parameter int SUM_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] COUNT_L = 4'(COUNT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             last;
  logic [SUM_W:0]   sum_ext;
  logic             carry;
  logic [SUM_W-1:0] acc_add;

  // Datapath: one extra bit catches the carry-out of the accumulator.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    accept  = in_valid && in_ready && !clr;
    last    = (cnt_q + 4'd1) == COUNT_L;
    sum_ext = {1'b0, acc_q} + (SUM_W+1)'(in_data);
    carry   = sum_ext[SUM_W];
`ifdef SEQ_ACCUM_SAT_EN
    // Once clamped, the accumulator sits at all-ones; adding zero keeps it there
    // and any non-zero sample carries again and re-clamps.
    acc_add = carry ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
`else
    acc_add = sum_ext[SUM_W-1:0];
`endif
  end

  // Next-state logic: clr overrides every handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    if (clr) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      ovf_d     = 1'b0;
      out_ovf_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            if (last) begin
              // Final sample: publish the total and restart the running sum.
              state_d   = S_HOLD;
              out_sum_d = acc_add;
              out_ovf_d = ovf_q | carry;
              cnt_d     = '0;
              acc_d     = '0;
              ovf_d     = 1'b0;
            end else begin
              state_d = S_ACCUM;
              cnt_d   = cnt_q + 4'd1;
              acc_d   = acc_add;
              ovf_d   = ovf_q | carry;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d   = S_IDLE;
            out_ovf_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  // Outputs decode from registers only; in_ready depends on state alone.
  always_comb begin
    in_ready  = (state_q != S_HOLD);
    out_valid = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
    out_sum   = out_sum_q;
    out_ovf   = out_ovf_q;
  end

endmodule
